bcd_scan_counter: RTL and testbench

//  Parametrised N-digit BCD up/down counter with built-in time-multiplexed
//  7-segment driver; next generation of the fixed 3-digit display counter.

---
 rtl/bcd_scan_counter_if.sv | 32 +++
 rtl/bcd_scan_counter.sv | 167 ++++++++++++++++
 tb/tb_bcd_scan_counter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/bcd_scan_counter_if.sv
//------------------------------------------------------------------------------
// Module      : bcd_scan_counter_if
// Description : Control/status bundle of the BCD scan counter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface bcd_scan_counter_if #(
    parameter int NUM_DIGITS = 3
);
    logic                      enable;
    logic                      up_down;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   load_value;
    logic                      blank_lz;
    logic [4*NUM_DIGITS-1:0]   count_bcd;
    logic                      wrap;
    logic [6:0]                seg_out;
    logic [NUM_DIGITS-1:0]     digit_sel;

    modport master (
        output enable, up_down, load, load_value, blank_lz,
        input  count_bcd, wrap, seg_out, digit_sel
    );

    modport slave (
        input  enable, up_down, load, load_value, blank_lz,
        output count_bcd, wrap, seg_out, digit_sel
    );
endinterface

`default_nettype wire

// File: rtl/bcd_scan_counter.sv
//------------------------------------------------------------------------------
// Module      : bcd_scan_counter
// Description : N-digit BCD up/down counter with multiplexed 7-segment driver.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd_scan_counter #(
    parameter int NUM_DIGITS     = 3,
    parameter int TICK_DIV       = 1000000,
    parameter int SCAN_DIV       = 1000,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int SEL_ACTIVE_LOW = 0
) (
    input  logic               clk,
    input  logic               rst,
    bcd_scan_counter_if.slave  bus
);

    localparam int c_CW = 4 * NUM_DIGITS;
    localparam int c_PW = (TICK_DIV   > 1) ? $clog2(TICK_DIV)   : 1;
    localparam int c_SW = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
    localparam int c_IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [c_PW-1:0]       c_PRESC_LAST = c_PW'(TICK_DIV - 1);
    localparam logic [c_SW-1:0]       c_SCAN_LAST  = c_SW'(SCAN_DIV - 1);
    localparam logic [c_IW-1:0]       c_IDX_LAST   = c_IW'(NUM_DIGITS - 1);
    localparam logic [6:0]            c_SEG_MASK   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] c_SEL_MASK   = (SEL_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;
    localparam logic [NUM_DIGITS-1:0] c_SEL_RESET  = NUM_DIGITS'(1);

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'h3F;
            4'd1:    glyph = 7'h06;
            4'd2:    glyph = 7'h5B;
            4'd3:    glyph = 7'h4F;
            4'd4:    glyph = 7'h66;
            4'd5:    glyph = 7'h6D;
            4'd6:    glyph = 7'h7D;
            4'd7:    glyph = 7'h07;
            4'd8:    glyph = 7'h7F;
            4'd9:    glyph = 7'h6F;
            default: glyph = 7'h00;
        endcase
    endfunction

    logic [c_PW-1:0]       r_presc;
    logic [c_CW-1:0]       r_count;
    logic                  r_wrap;
    logic [c_SW-1:0]       r_scan_cnt;
    logic [c_IW-1:0]       r_scan_idx;
    logic [6:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_sel;

    logic                  w_tick;
    logic                  w_carry;
    logic [c_CW-1:0]       w_next_count;
    logic [c_CW-1:0]       w_load_count;
    logic [NUM_DIGITS-1:0] w_upper_zero;
    logic                  w_zero_run;
    logic [3:0]            w_cur_digit;
    logic                  w_cur_blank;
    logic [NUM_DIGITS-1:0] w_onehot;
    logic [6:0]            w_glyph;

    assign w_tick = bus.enable && (r_presc == c_PRESC_LAST);

    // Ripple carry/borrow: w_carry left set after the top digit means roll-over.
    always_comb begin
        w_carry      = 1'b1;
        w_next_count = r_count;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_carry) begin
                if (bus.up_down) begin
                    if (r_count[4*i +: 4] == 4'd9) begin
                        w_next_count[4*i +: 4] = 4'd0;
                    end else begin
                        w_next_count[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                        w_carry                = 1'b0;
                    end
                end else begin
                    if (r_count[4*i +: 4] == 4'd0) begin
                        w_next_count[4*i +: 4] = 4'd9;
                    end else begin
                        w_next_count[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
                        w_carry                = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        w_load_count = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_load_count[4*i +: 4] = (bus.load_value[4*i +: 4] > 4'd9) ? 4'd0 : bus.load_value[4*i +: 4];
        end
    end

    // w_upper_zero[i]: digit i and every digit above it are zero.
    always_comb begin
        w_zero_run   = 1'b1;
        w_upper_zero = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_zero_run      = w_zero_run && (r_count[4*i +: 4] == 4'd0);
            w_upper_zero[i] = w_zero_run;
        end
    end

    always_comb begin
        w_cur_digit = 4'd0;
        w_cur_blank = 1'b0;
        w_onehot    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_scan_idx == c_IW'(i)) begin
                w_cur_digit = r_count[4*i +: 4];
                w_cur_blank = bus.blank_lz && (i != 0) && w_upper_zero[i];
                w_onehot[i] = 1'b1;
            end
        end
        w_glyph = w_cur_blank ? 7'h00 : glyph(w_cur_digit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc    <= '0;
            r_count    <= '0;
            r_wrap     <= 1'b0;
            r_scan_cnt <= '0;
            r_scan_idx <= '0;
            r_seg      <= 7'h3F ^ c_SEG_MASK;
            r_sel      <= c_SEL_RESET ^ c_SEL_MASK;
        end else begin
            r_wrap <= 1'b0;
            // Load wins over a coincident tick and restarts the prescale period.
            if (bus.load) begin
                r_count <= w_load_count;
                r_presc <= '0;
            end else if (bus.enable) begin
                r_presc <= w_tick ? '0 : r_presc + 1'b1;
                if (w_tick) begin
                    r_count <= w_next_count;
                    r_wrap  <= w_carry;
                end
            end

            if (r_scan_cnt == c_SCAN_LAST) begin
                r_scan_cnt <= '0;
                r_scan_idx <= (r_scan_idx == c_IDX_LAST) ? '0 : r_scan_idx + 1'b1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end

            r_seg <= w_glyph ^ c_SEG_MASK;
            r_sel <= w_onehot ^ c_SEL_MASK;
        end
    end

    assign bus.count_bcd = r_count;
    assign bus.wrap      = r_wrap;
    assign bus.seg_out   = r_seg;
    assign bus.digit_sel = r_sel;

endmodule

`default_nettype wire

// File: tb/tb_bcd_scan_counter.sv
//------------------------------------------------------------------------------
// Module      : tb_bcd_scan_counter
// Description : Scoreboard bench for two bcd_scan_counter configurations.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bcd_scan_counter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bcd_scan_counter_if #(.NUM_DIGITS(3)) bus_a ();
    bcd_scan_counter_if #(.NUM_DIGITS(4)) bus_b ();

    bcd_scan_counter #(
        .NUM_DIGITS(3), .TICK_DIV(4), .SCAN_DIV(2),
        .SEG_ACTIVE_LOW(0), .SEL_ACTIVE_LOW(0)
    ) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));

    bcd_scan_counter #(
        .NUM_DIGITS(4), .TICK_DIV(3), .SCAN_DIV(3),
        .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)
    ) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    localparam int P_N   [2] = '{3, 4};
    localparam int P_TD  [2] = '{4, 3};
    localparam int P_SD  [2] = '{2, 3};
    localparam int P_SAL [2] = '{0, 1};
    localparam int P_EAL [2] = '{0, 1};

    typedef struct {
        logic [15:0] count;
        logic        wrap;
        logic [6:0]  seg;
        logic [3:0]  sel;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_checks = 0;
    int   n_errors = 0;

    logic [6:0] glyph_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                   7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Reference state: count as a plain integer, enabled cycles since the
    // last load/reset, and clock cycles since reset.
    int m_val [2];
    int m_en  [2];
    int m_cyc [2];

    logic        s_en, s_ud, s_ld, s_bl;
    logic [15:0] s_lv;

    function automatic int pow10(input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    function automatic int sanitize(input logic [15:0] v, input int n);
        int r = 0;
        int nib;
        for (int i = 0; i < n; i++) begin
            nib = int'((v >> (4 * i)) & 16'hF);
            if (nib > 9) nib = 0;
            r = r + nib * pow10(i);
        end
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int v, input int n);
        logic [15:0] b = '0;
        for (int i = 0; i < n; i++) b[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return b;
    endfunction

    task automatic model_step(input int k, output exp_t e);
        int   n, modv, idx, upper;
        logic tick;
        n       = P_N[k];
        modv    = pow10(n);
        e.wrap  = 1'b0;
        if (rst) begin
            m_val[k] = 0;
            m_en[k]  = 0;
            m_cyc[k] = 0;
            e.seg    = 7'h3F;
            e.sel    = 4'd1;
        end else begin
            idx   = (m_cyc[k] / P_SD[k]) % n;
            upper = m_val[k] / pow10(idx);
            e.sel = 4'(1 << idx);
            e.seg = (s_bl && idx > 0 && upper == 0) ? 7'h00 : glyph_tab[upper % 10];
            if (s_ld) begin
                m_val[k] = sanitize(s_lv, n);
                m_en[k]  = 0;
            end else if (s_en) begin
                tick    = ((m_en[k] % P_TD[k]) == P_TD[k] - 1);
                m_en[k] = m_en[k] + 1;
                if (tick) begin
                    if (s_ud) begin
                        e.wrap   = (m_val[k] == modv - 1);
                        m_val[k] = (m_val[k] + 1) % modv;
                    end else begin
                        e.wrap   = (m_val[k] == 0);
                        m_val[k] = (m_val[k] + modv - 1) % modv;
                    end
                end
            end
            m_cyc[k] = m_cyc[k] + 1;
        end
        if (P_SAL[k] != 0) e.seg = e.seg ^ 7'h7F;
        if (P_EAL[k] != 0) e.sel = e.sel ^ 4'((1 << n) - 1);
        e.count = to_bcd(m_val[k], n);
    endtask

    task automatic cycle(input logic r, input logic en, input logic ud,
                         input logic ld, input logic bl, input logic [15:0] v);
        exp_t ea, eb;
        rst  = r;  s_en = en; s_ud = ud; s_ld = ld; s_bl = bl; s_lv = v;
        bus_a.enable = en; bus_a.up_down = ud; bus_a.load = ld;
        bus_a.blank_lz = bl; bus_a.load_value = v[11:0];
        bus_b.enable = en; bus_b.up_down = ud; bus_b.load = ld;
        bus_b.blank_lz = bl; bus_b.load_value = v;
        model_step(0, ea);
        model_step(1, eb);
        @(posedge clk);
        q_a.push_back(ea);
        q_b.push_back(eb);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
        end
    endtask

    // Monitor: the DUT presents a fresh output set every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                check("a_count", {4'h0, bus_a.count_bcd}, e.count);
                check("a_wrap",  {15'h0, bus_a.wrap},     {15'h0, e.wrap});
                check("a_seg",   {9'h0, bus_a.seg_out},   {9'h0, e.seg});
                check("a_sel",   {13'h0, bus_a.digit_sel}, {12'h0, e.sel});
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                check("b_count", bus_b.count_bcd,         e.count);
                check("b_wrap",  {15'h0, bus_b.wrap},     {15'h0, e.wrap});
                check("b_seg",   {9'h0, bus_b.seg_out},   {9'h0, e.seg});
                check("b_sel",   {12'h0, bus_b.digit_sel}, {12'h0, e.sel});
            end
        end
    end

    initial begin
        logic        r, en, ld;
        logic [15:0] v;
        #1;
        repeat (3) cycle(1, 0, 1, 0, 0, 16'h0);

        // Count up through roll-over.
        cycle(0, 1, 1, 1, 0, 16'h0998);
        repeat (14) cycle(0, 1, 1, 0, 0, 16'h0);

        // Count down through roll-over, then hold.
        cycle(0, 1, 0, 1, 0, 16'h0000);
        repeat (10) cycle(0, 1, 0, 0, 0, 16'h0);
        repeat (6)  cycle(0, 0, 0, 0, 0, 16'h0);

        // Load with an invalid nibble landing on a tick cycle.
        cycle(0, 1, 1, 1, 0, 16'h0000);
        repeat (3) cycle(0, 1, 1, 0, 0, 16'h0);
        cycle(0, 1, 1, 1, 0, 16'h01A5);
        repeat (9) cycle(0, 1, 1, 0, 0, 16'h0);

        // Leading-zero blanking on and off.
        cycle(0, 0, 1, 1, 1, 16'h0007);
        repeat (12) cycle(0, 0, 1, 0, 1, 16'h0);
        repeat (12) cycle(0, 0, 1, 0, 0, 16'h0);

        // Reset in the middle of counting and scanning.
        repeat (5) cycle(0, 1, 1, 0, 0, 16'h0);
        cycle(1, 1, 1, 0, 0, 16'h0);
        repeat (4) cycle(0, 1, 1, 0, 1, 16'h0);

        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 63) == 0);
            en = ($urandom_range(0, 3) != 0);
            ld = ($urandom_range(0, 15) == 0);
            v  = 16'($urandom);
            if (ld && $urandom_range(0, 1) == 1) v = ($urandom_range(0, 1) == 1) ? 16'h9999 : 16'h0000;
            cycle(r, en, 1'($urandom), ld, 1'($urandom), v);
        end

        @(negedge clk);
        @(negedge clk);
        #1;
        check("queue_drain", 16'(q_a.size() + q_b.size()), 16'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
